// File: rtl/aqp_sync_fifo.sv
// Parametrised single-clock FIFO with wrap-bit pointers, occupancy count,
// programmable almost-full/almost-empty, sticky error flags and optional FWFT output stage.
module aqp_sync_fifo #(
    parameter int WIDTH         = 9,
    parameter int DEPTH_LOG2    = 4,
    parameter int AFULL_THRESH  = 8,
    parameter int AEMPTY_THRESH = 1,
    parameter bit FWFT          = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wrdata,
    input  logic                  wr_en,
    output logic [WIDTH-1:0]      rddata,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              DEPTH   = 2 ** DEPTH_LOG2;
    localparam int              PW      = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]   DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0]   AF_C    = PW'(AFULL_THRESH);
    localparam logic [PW-1:0]   AE_C    = PW'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wrptr_q, wrptr_d;
    logic [PW-1:0]    rdptr_q, rdptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] rddata_q, rddata_d;

    logic             wr_acc;
    logic             rd_acc;
    logic             ram_empty;
    logic             mem_we;
    logic [WIDTH-1:0] head;

    assign head = mem[rdptr_q[PW-2:0]];

    always_comb begin
        wrptr_d   = wrptr_q;
        rdptr_d   = rdptr_q;
        rddata_d  = rddata_q;
        ov_d      = ov_q;
        mem_we    = 1'b0;
        wr_acc    = wr_en && !full_q;
        rd_acc    = rd_en && !empty_q;
        ram_empty = (wrptr_q == rdptr_q);
        ovf_d     = ovf_q | (wr_en & full_q);
        unf_d     = unf_q | (rd_en & empty_q);

        if (FWFT) begin
            // The output register is refilled from RAM on a pop; writes bypass RAM
            // whenever the output stage would otherwise be left empty.
            if (rd_acc && !ram_empty) begin
                rddata_d = head;
                rdptr_d  = rdptr_q + PW'(1);
            end
            if (wr_acc) begin
                if (!ov_q || (rd_acc && ram_empty)) begin
                    rddata_d = wrdata;
                end else begin
                    mem_we  = 1'b1;
                    wrptr_d = wrptr_q + PW'(1);
                end
                ov_d = 1'b1;
            end else if (rd_acc && ram_empty) begin
                ov_d = 1'b0;
            end
        end else begin
            if (rd_acc) begin
                rddata_d = head;
                rdptr_d  = rdptr_q + PW'(1);
            end
            if (wr_acc) begin
                mem_we  = 1'b1;
                wrptr_d = wrptr_q + PW'(1);
            end
        end

        // Flush overrides both requests but leaves the last read word on rddata.
        if (flush) begin
            wrptr_d  = '0;
            rdptr_d  = '0;
            ov_d     = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            mem_we   = 1'b0;
            rddata_d = rddata_q;
        end

        count_d  = wrptr_d - rdptr_d + PW'(ov_d);
        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_C);
        afull_d  = (count_d >= AF_C);
        aempty_d = (count_d <= AE_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrptr_q  <= '0;
            rdptr_q  <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ov_q     <= 1'b0;
            rddata_q <= '0;
        end else begin
            wrptr_q  <= wrptr_d;
            rdptr_q  <= rdptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            ov_q     <= ov_d;
            rddata_q <= rddata_d;
        end
    end

    // Storage is never reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wrptr_q[PW-2:0]] <= wrdata;
        end
    end

    assign rddata       = rddata_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_aqp_sync_fifo.sv
// Bench for aqp_sync_fifo: standard and FWFT instances driven with identical stimulus,
// checked against a queue scoreboard, a vector table and hand-written corner sequences.
module tb_aqp_sync_fifo;

    localparam int W     = 9;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 8;
    localparam int AE    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, flush, wr_en, rd_en;
    logic [W-1:0] wrdata;

    logic [W-1:0] rddata_s, rddata_f;
    logic         empty_s, full_s, af_s, ae_s, ovf_s, unf_s;
    logic         empty_f, full_f, af_f, ae_f, ovf_f, unf_f;
    logic [DL:0]  count_s, count_f;

    aqp_sync_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(1'b0)) u_std (
        .clk(clk), .reset(reset), .flush(flush), .wrdata(wrdata), .wr_en(wr_en),
        .rddata(rddata_s), .rd_en(rd_en), .empty(empty_s), .full(full_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    aqp_sync_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset(reset), .flush(flush), .wrdata(wrdata), .wr_en(wr_en),
        .rddata(rddata_f), .rd_en(rd_en), .empty(empty_f), .full(full_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] sb[$];
    bit           m_ovf, m_unf;
    logic [W-1:0] m_rd;

    typedef struct {
        bit wr; bit rd; int wd;
        int cnt; bit emp; bit ful; bit af; bit ae; bit ovf; bit unf;
        int rd_std; int head;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input bit which, input int cnt, input bit emp,
                             input bit ful, input bit af, input bit ae, input bit ovf, input bit unf);
        if (which == 1'b0) begin
            chk({nm, ".count"}, int'(count_s), cnt);
            chk({nm, ".empty"}, int'(empty_s), int'(emp));
            chk({nm, ".full"},  int'(full_s),  int'(ful));
            chk({nm, ".afull"}, int'(af_s),    int'(af));
            chk({nm, ".aempty"}, int'(ae_s),   int'(ae));
            chk({nm, ".overflow"}, int'(ovf_s), int'(ovf));
            chk({nm, ".underflow"}, int'(unf_s), int'(unf));
        end else begin
            chk({nm, ".count"}, int'(count_f), cnt);
            chk({nm, ".empty"}, int'(empty_f), int'(emp));
            chk({nm, ".full"},  int'(full_f),  int'(ful));
            chk({nm, ".afull"}, int'(af_f),    int'(af));
            chk({nm, ".aempty"}, int'(ae_f),   int'(ae));
            chk({nm, ".overflow"}, int'(ovf_f), int'(ovf));
            chk({nm, ".underflow"}, int'(unf_f), int'(unf));
        end
    endtask

    task automatic check_all();
        int n;
        n = sb.size();
        check_dut("std", 1'b0, n, n == 0, n == DEPTH, n >= AF, n <= AE, m_ovf, m_unf);
        check_dut("fwft", 1'b1, n, n == 0, n == DEPTH, n >= AF, n <= AE, m_ovf, m_unf);
        chk("std.rddata", int'(rddata_s), int'(m_rd));
        if (n > 0) chk("fwft.rddata", int'(rddata_f), int'(sb[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit wr, input bit rd, input bit fl, input logic [W-1:0] wd);
        bit fullm, empm;
        wr_en = wr; rd_en = rd; flush = fl; wrdata = wd;
        fullm = (sb.size() == DEPTH);
        empm  = (sb.size() == 0);
        if (fl) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && fullm) m_ovf = 1'b1;
            if (rd && empm)  m_unf = 1'b1;
            if (rd && !empm) m_rd = sb.pop_front();
            if (wr && !fullm) sb.push_back(wd);
        end
        tick();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        check_all();
    endtask

    task automatic do_reset(input bit wr, input bit rd);
        reset = 1'b1; wr_en = wr; rd_en = rd; wrdata = 9'h1C3;
        tick();
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        sb.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rd = '0;
        check_all();
    endtask

    function automatic vec_t mk(bit wr, bit rd, int wd, int cnt, bit emp, bit ful, bit af,
                                bit ae, bit ovf, bit unf, int rd_std, int head);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wd = wd; v.cnt = cnt; v.emp = emp; v.ful = ful;
        v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf; v.rd_std = rd_std; v.head = head;
        return v;
    endfunction

    initial begin
        int rv, pw, pr;
        reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wrdata = '0;
        m_rd = '0;

        // Fill to full, overflow, drain in order, underflow.
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, 256 + i, i + 1, 0, i == 15, (i + 1) >= 8, (i + 1) <= 1, 0, 0, 0, 256));
        tbl.push_back(mk(1, 0, 9'h1FF, 16, 0, 1, 1, 0, 1, 0, 0, 256));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(0, 1, 0, 15 - i, i == 15, 0, (15 - i) >= 8, (15 - i) <= 1, 1, 0, 256 + i, 257 + i));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 9'h10F, 0));

        do_reset(1'b0, 1'b0);
        chk("reset.std.rddata", int'(rddata_s), 0);
        chk("reset.std.empty", int'(empty_s), 1);
        chk("reset.fwft.aempty", int'(ae_f), 1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].wr, tbl[i].rd, 1'b0, W'(tbl[i].wd));
            check_dut("tbl.std", 1'b0, tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].af, tbl[i].ae, tbl[i].ovf, tbl[i].unf);
            check_dut("tbl.fwft", 1'b1, tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].af, tbl[i].ae, tbl[i].ovf, tbl[i].unf);
            chk("tbl.std.rddata", int'(rddata_s), tbl[i].rd_std);
            if (!tbl[i].emp) chk("tbl.fwft.rddata", int'(rddata_f), tbl[i].head);
        end

        // FWFT fall-through of the first word, then advance on pop.
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 9'h0AA);
        chk("fwft_first.empty", int'(empty_f), 0);
        chk("fwft_first.rddata", int'(rddata_f), 9'h0AA);
        cyc(1'b1, 1'b0, 1'b0, 9'h0BB);
        cyc(1'b0, 1'b1, 1'b0, 9'h000);
        chk("fwft_adv.rddata", int'(rddata_f), 9'h0BB);
        chk("std_pop.rddata", int'(rddata_s), 9'h0AA);

        // Simultaneous read and write while full, then while empty.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, W'(256 + i));
        cyc(1'b1, 1'b1, 1'b0, 9'h1EE);
        chk("full_both.count", int'(count_s), 15);
        chk("full_both.overflow", int'(ovf_s), 1);
        chk("full_both.std.rddata", int'(rddata_s), 9'h100);
        chk("full_both.fwft.rddata", int'(rddata_f), 9'h101);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0, 9'h000);
        cyc(1'b1, 1'b1, 1'b0, 9'h055);
        chk("empty_both.count", int'(count_s), 1);
        chk("empty_both.underflow", int'(unf_s), 1);
        chk("empty_both.fwft.count", int'(count_f), 1);
        chk("empty_both.fwft.rddata", int'(rddata_f), 9'h055);

        // Steady state at count 5 across several pointer wraps.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, W'(i));
        for (int k = 0; k < 100; k++) begin
            cyc(1'b1, 1'b1, 1'b0, W'(5 + k));
            chk("steady.std.count", int'(count_s), 5);
            chk("steady.fwft.count", int'(count_f), 5);
        end

        // Flush with a concurrent write at count 6.
        do_reset(1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 9'h000);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, W'(16 + i));
        cyc(1'b0, 1'b1, 1'b0, 9'h000);
        chk("pre_flush.count", int'(count_s), 6);
        cyc(1'b1, 1'b0, 1'b1, 9'h3CC & 9'h1FF);
        chk("flush.count", int'(count_s), 0);
        chk("flush.empty", int'(empty_s), 1);
        chk("flush.overflow", int'(ovf_s), 0);
        chk("flush.underflow", int'(unf_s), 0);
        chk("flush.fwft.empty", int'(empty_f), 1);
        chk("flush.std.rddata", int'(rddata_s), 9'h010);
        cyc(1'b0, 1'b0, 1'b0, 9'h000);
        chk("flush_drop.count", int'(count_f), 0);
        cyc(1'b1, 1'b0, 1'b0, 9'h1A5);
        chk("post_flush.fwft.rddata", int'(rddata_f), 9'h1A5);
        cyc(1'b0, 1'b1, 1'b0, 9'h000);
        chk("post_flush.std.rddata", int'(rddata_s), 9'h1A5);

        // Same again, cleared by reset instead of flush.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, W'(48 + i));
        do_reset(1'b1, 1'b0);
        chk("rst_mid.count", int'(count_s), 0);
        chk("rst_mid.empty", int'(empty_f), 1);
        chk("rst_mid.std.rddata", int'(rddata_s), 0);
        cyc(1'b1, 1'b0, 1'b0, 9'h0C7);
        chk("rst_mid.fwft.rddata", int'(rddata_f), 9'h0C7);

        // Randomised traffic in write-heavy, read-heavy and balanced phases.
        for (int c = 0; c < 10000; c++) begin
            case ((c / 500) % 3)
                0:       begin pw = 75; pr = 35; end
                1:       begin pw = 35; pr = 75; end
                default: begin pw = 55; pr = 55; end
            endcase
            if (c == 5000) begin
                do_reset(1'b1, 1'b1);
            end else begin
                rv = int'($urandom_range(0, 299));
                cyc(int'($urandom_range(0, 99)) < pw, int'($urandom_range(0, 99)) < pr,
                    rv == 0, W'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
